shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//  Multi-cycle shift controller for the ALU shift path: accepts an operand, an amount
//  and an op code, then shifts one bit per clock.
//  Reports the result with the ALU flag set (C,N,V,Z) through a start/done handshake.
//  Sits beside the combinational ALU. Sequences a 1-bit shift stage instead of a full barrel.
// PARAMETERS
//  M   4   operand / result / shift-amount width (M >= 2)
// PORTS
//  clk    in   1     system clock, rising edge
//  rst    in   1     reset, asynchronous, active-high
//  start  in   1     request; sampled only in IDLE
//  op     in   2     00 SLL, 01 SRL, 10 SRA, 11 ROL; latched with start
//  A      in   M     shiftee; latched with start
//  B      in   M     shift amount (unsigned); latched with start
//  busy   out  1     1 while state != IDLE
//  done   out  1     1-cycle pulse, R/flags valid
//  R      out  M     result; registered, held until next accepted start
//  C      out  1     carry = last bit shifted out (0 if no shift)
//  N      out  1     R[M-1]
//  V      out  1     amount overflow flag
//  Z      out  1     R == 0
// BEHAVIOUR
//  Reset: state=IDLE; acc, count, R=0; C=N=V=0; Z=1; busy=done=0. Applies immediately, also mid-operation.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE, start=1 at edge: acc<=A, op latched, C<=0.
//   k = (op==ROL) ? B mod M : min(B, M). count<=k. V<=(op!=ROL && B>=M).
//   Next state SHIFT if k>0, else DONE.
//  SHIFT, each edge: acc<=step(acc), C<=bit shifted out, count<=count-1; when count==1 -> DONE.
//   SLL: {acc[M-2:0],0}, out acc[M-1]. SRL: {0,acc[M-1:1]}, out acc[0].
//   SRA: {acc[M-1],acc[M-1:1]}, out acc[0]. ROL: {acc[M-2:0],acc[M-1]}, out acc[M-1].
//  DONE: done=1 for exactly one cycle. R=acc; N,Z from R. Next state IDLE.
//  Latency: done is high in the cycle after edge k+1 following the accepting edge (k=0 -> next cycle).
//  start while busy (SHIFT or DONE): ignored, no queueing. A/B/op changes after the accept edge have no effect.
//  R/C/N/V/Z update only on DONE entry, then hold through IDLE.
//  count width $clog2(M+1). Saturation at M makes SLL/SRL yield 0 and SRA yield sign-fill for any B>=M.
//  Illegal state encoding -> IDLE.
// STRUCTURE
//  shift_seq_pkg: typedef enum logic[1:0] state_t {IDLE,SHIFT,DONE};
//   typedef enum logic[1:0] shop_t {SLL,SRL,SRA,ROL}.
//  Sub-module shift_step #(M): combinational 1-bit shift of acc by op, returns {next, out_bit}.
//  Top: FSM, count register, acc register, flag logic.
// TESTING (M=4; "t+n" = n cycles after the accepting edge)
//  1 A=1011 B=1 SLL -> done @t+2, R=0110 C=1 N=0 V=0 Z=0.
//  2 A=1000 B=3 SRA -> done @t+4, R=1111 C=0 N=1 V=0 Z=0.
//  3 A=0000 B=0 SRL -> done @t+1, R=0000 C=0 V=0 Z=1; busy high for one cycle only.
//  4 A=1001 B=6 SRL -> count saturates to 4, done @t+5, R=0000 C=1 V=1 Z=1.
//  5 A=1001 B=5 ROL -> k=1, done @t+2, R=0011 C=1 V=0 N=0.
//  6 A=1011 B=3 SLL, pulse start again @t+1, then assert rst @t+2 (mid-SHIFT).
//    -> second start ignored; all outputs at reset values immediately; no done.
//    -> a new start after rst falls completes normally.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared types for the sequential shift controller: FSM states and shift op codes.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLL = 2'd0,
        SRL = 2'd1,
        SRA = 2'd2,
        ROL = 2'd3
    } shop_t;

endpackage

// File: rtl/shift_step.sv
// One-bit shift stage: produces the next accumulator value and the bit shifted out.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int M = 4
) (
    input  logic [M-1:0] i_acc,
    input  shop_t        i_op,
    output logic [M-1:0] o_next,
    output logic         o_out
);

    // Select the single-bit move for the latched op code
    always_comb begin
        o_next = i_acc;
        o_out  = 1'b0;
        case (i_op)
            SLL: begin
                o_next = {i_acc[M-2:0], 1'b0};
                o_out  = i_acc[M-1];
            end
            SRL: begin
                o_next = {1'b0, i_acc[M-1:1]};
                o_out  = i_acc[0];
            end
            SRA: begin
                o_next = {i_acc[M-1], i_acc[M-1:1]};
                o_out  = i_acc[0];
            end
            ROL: begin
                o_next = {i_acc[M-2:0], i_acc[M-1]};
                o_out  = i_acc[M-1];
            end
            default: begin
                o_next = i_acc;
                o_out  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: latches an operand on start, shifts one bit per
// clock, then presents the result and C/N/V/Z flags with a one-cycle done pulse.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [M-1:0] A,
    input  logic [M-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] R,
    output logic         C,
    output logic         N,
    output logic         V,
    output logic         Z
);

    localparam int          CW    = $clog2(M + 1);
    localparam logic [M:0]  M_EXT = M[M:0];

    state_t          r_state;
    state_t          w_next_state;
    logic [M-1:0]    r_acc;
    logic [CW-1:0]   r_count;
    shop_t           r_op;
    logic            r_carry;
    logic            r_vpend;

    logic [CW-1:0]   w_k;
    logic            w_v;
    logic            w_accept;
    logic            w_last_shift;
    logic [M-1:0]    w_step_next;
    logic            w_step_out;

    shift_step #(.M(M)) u_step (
        .i_acc  (r_acc),
        .i_op   (r_op),
        .o_next (w_step_next),
        .o_out  (w_step_out)
    );

    // Shift count for a new request: rotates wrap modulo M, other ops saturate at M
    always_comb begin
        w_k = '0;
        w_v = 1'b0;
        if (shop_t'(op) == ROL) begin
            w_k = CW'({1'b0, B} % M_EXT);
            w_v = 1'b0;
        end else if ({1'b0, B} >= M_EXT) begin
            w_k = CW'(M);
            w_v = 1'b1;
        end else begin
            w_k = CW'(B);
            w_v = 1'b0;
        end
    end

    assign w_accept     = (r_state == IDLE) && start;
    assign w_last_shift = (r_state == SHIFT) && (r_count <= CW'(1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; unused encodings fall back to IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = (w_k != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (r_count <= CW'(1)) begin
                    w_next_state = DONE;
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Working registers: load on accept, step once per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_count <= '0;
            r_op    <= SLL;
            r_carry <= 1'b0;
            r_vpend <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= A;
            r_count <= w_k;
            r_op    <= shop_t'(op);
            r_carry <= 1'b0;
            r_vpend <= w_v;
        end else if (r_state == SHIFT) begin
            r_acc   <= w_step_next;
            r_count <= r_count - CW'(1);
            r_carry <= w_step_out;
        end
    end

    // Result and flags update only when entering DONE, then hold until the next result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            R <= '0;
            C <= 1'b0;
            N <= 1'b0;
            V <= 1'b0;
            Z <= 1'b1;
        end else if (w_accept && (w_k == '0)) begin
            R <= A;
            C <= 1'b0;
            N <= A[M-1];
            V <= w_v;
            Z <= (A == '0);
        end else if (w_last_shift) begin
            R <= w_step_next;
            C <= w_step_out;
            N <= w_step_next[M-1];
            V <= r_vpend;
            Z <= (w_step_next == '0);
        end
    end

    assign busy = (r_state != IDLE);
    assign done = (r_state == DONE);

endmodule
